// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin sharing of one GCD engine between two requesters; GCD_SCHEDULER_ZERO_BYPASS_EN answers zero-operand requests locally.
// Latency: gnt and eng_begin one cycle after req is sampled in IDLE; done one cycle after eng_complete is first sampled high.
// Backpressure: req is held until done; no grant while the engine is in use or still asserting eng_complete.

module gcd_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] gcd0,
  output logic [WIDTH-1:0] gcd1,
  output logic             eng_begin,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  input  logic             eng_complete,
  input  logic [WIDTH-1:0] eng_gcd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             gnt0_d, gnt1_d, done0_d, done1_d, eng_begin_d;
  logic [WIDTH-1:0] gcd0_d, gcd1_d, eng_a_d, eng_b_d;
  logic             pick, bypass;
  logic [WIDTH-1:0] sel_a, sel_b;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick  = (req0 && req1) ? ~last_q : req1;
    sel_a = pick ? a1 : a0;
    sel_b = pick ? b1 : b0;
  end

`ifdef GCD_SCHEDULER_ZERO_BYPASS_EN
  assign bypass = (sel_a == '0) || (sel_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    eng_begin_d = 1'b0;
    gcd0_d      = gcd0;
    gcd1_d      = gcd1;
    eng_a_d     = eng_a;
    eng_b_d     = eng_b;

    case (state_q)
      IDLE: begin
        // A lingering eng_complete from a previous or reset operation blocks arbitration.
        if (!eng_complete && (req0 || req1)) begin
          last_d = pick;
          gnt0_d = ~pick;
          gnt1_d = pick;
          if (bypass) begin
            // gcd(x,0) = x, so the OR of the operands is the answer.
            done0_d = ~pick;
            done1_d = pick;
            if (pick) gcd1_d = sel_a | sel_b;
            else      gcd0_d = sel_a | sel_b;
          end else begin
            owner_d     = pick;
            eng_a_d     = sel_a;
            eng_b_d     = sel_b;
            eng_begin_d = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (eng_complete) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (owner_q) gcd1_d = eng_gcd;
          else         gcd0_d = eng_gcd;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!eng_complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      eng_begin <= 1'b0;
      gcd0      <= '0;
      gcd1      <= '0;
      eng_a     <= '0;
      eng_b     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      eng_begin <= eng_begin_d;
      gcd0      <= gcd0_d;
      gcd1      <= gcd1_d;
      eng_a     <= eng_a_d;
      eng_b     <= eng_b_d;
    end
  end

endmodule

// File: tb/tb_gcd_scheduler.sv
// Bench for gcd_scheduler: directed scenarios plus randomized requesters, checked against a
// transaction-level reference of the scheduling rules and a behavioural GCD engine.

module tb_gcd_scheduler;

  localparam int W = 16;
`ifdef GCD_SCHEDULER_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, eng_begin;
  logic [W-1:0] gcd0, gcd1, eng_a, eng_b;
  logic         eng_complete;
  logic [W-1:0] eng_gcd;

  bit           r_req [2];
  logic [W-1:0] r_a [2];
  logic [W-1:0] r_b [2];
  bit           granted [2];

  assign req0 = r_req[0];
  assign req1 = r_req[1];
  assign a0   = r_a[0];
  assign b0   = r_b[0];
  assign a1   = r_a[1];
  assign b1   = r_b[1];

  gcd_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .gcd0(gcd0), .gcd1(gcd1),
    .eng_begin(eng_begin), .eng_a(eng_a), .eng_b(eng_b),
    .eng_complete(eng_complete), .eng_gcd(eng_gcd)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gcnt [2];
  int dcnt [2];
  int glog [$];
  bit rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    if ($urandom_range(0, 7) == 0) return '0;
    return W'($urandom_range(1, 1000));
  endfunction

  // Reference: one operation at a time, stage 0 = free, 1 = started, 2 = computing,
  // 3 = result delivered but engine still flagging completion.
  int           m_stage;
  int           m_last, m_owner;
  logic [W-1:0] m_res;
  bit           e_gnt [2];
  bit           e_done [2];
  bit           e_begin;
  logic [W-1:0] e_gcd [2];
  logic [W-1:0] e_ea, e_eb;

  task automatic model_update();
    int w;
    e_gnt   = '{1'b0, 1'b0};
    e_done  = '{1'b0, 1'b0};
    e_begin = 1'b0;
    if (rst) begin
      m_stage = 0;
      m_last  = 1;
      m_owner = 0;
      e_gcd   = '{'0, '0};
      e_ea    = '0;
      e_eb    = '0;
      return;
    end
    case (m_stage)
      0: if (!eng_complete && (r_req[0] || r_req[1])) begin
        w = (r_req[0] && r_req[1]) ? 1 - m_last : (r_req[1] ? 1 : 0);
        m_last   = w;
        e_gnt[w] = 1'b1;
        if (BYPASS && (r_a[w] == '0 || r_b[w] == '0)) begin
          e_done[w] = 1'b1;
          e_gcd[w]  = ref_gcd(r_a[w], r_b[w]);
        end else begin
          m_owner = w;
          m_res   = ref_gcd(r_a[w], r_b[w]);
          e_ea    = r_a[w];
          e_eb    = r_b[w];
          e_begin = 1'b1;
          m_stage = 1;
        end
      end
      1: m_stage = 2;
      2: if (eng_complete) begin
        e_done[m_owner] = 1'b1;
        e_gcd[m_owner]  = m_res;
        m_stage = 3;
      end
      default: if (!eng_complete) m_stage = 0;
    endcase
  endtask

  task automatic compare_outputs();
    check("gnt0", gnt0, e_gnt[0]);
    check("gnt1", gnt1, e_gnt[1]);
    check("done0", done0, e_done[0]);
    check("done1", done1, e_done[1]);
    check("eng_begin", eng_begin, e_begin);
    check("gcd0", gcd0, e_gcd[0]);
    check("gcd1", gcd1, e_gcd[1]);
    check("eng_a", eng_a, e_ea);
    check("eng_b", eng_b, e_eb);
  endtask

  // Behavioural engine: latency and completion-hold length random unless pinned.
  bit           en_pending, en_out, en_force;
  int           en_cnt, en_hold, dly_cfg, hold_cfg;
  logic [W-1:0] en_res;

  task automatic engine_update();
    if (rst) begin
      en_pending = 1'b0;
      en_hold    = 0;
      en_out     = 1'b0;
    end else begin
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) begin
          en_out  = 1'b0;
          eng_gcd = W'($urandom);
        end
      end else if (en_pending) begin
        en_cnt--;
        if (en_cnt == 0) begin
          en_out     = 1'b1;
          eng_gcd    = en_res;
          en_hold    = (hold_cfg == 0) ? $urandom_range(1, 3) : hold_cfg;
          en_pending = 1'b0;
        end
      end
      if (eng_begin) begin
        en_pending = 1'b1;
        en_cnt     = (dly_cfg == 0) ? $urandom_range(1, 4) : dly_cfg;
        en_res     = ref_gcd(eng_a, eng_b);
      end
    end
    eng_complete = en_out | en_force;
  endtask

  task automatic requester_update();
    bit g, d;
    for (int p = 0; p < 2; p++) begin
      g = (p == 1) ? gnt1 : gnt0;
      d = (p == 1) ? done1 : done0;
      if (g) granted[p] = 1'b1;
      if (d) begin
        granted[p] = 1'b0;
        if ($urandom_range(0, 3) != 0) r_req[p] = 1'b0;
      end else if (r_req[p] && !granted[p] && $urandom_range(0, 9) == 0) begin
        r_req[p] = 1'b0;
      end else if (r_req[p] && granted[p] && $urandom_range(0, 9) == 0) begin
        r_req[p] = 1'b0;
      end else if (!r_req[p] && !granted[p] && $urandom_range(0, 2) == 0) begin
        r_req[p] = 1'b1;
        r_a[p]   = rand_op();
        r_b[p]   = rand_op();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_update();
    compare_outputs();
    if (gnt0)  begin gcnt[0]++; glog.push_back(0); end
    if (gnt1)  begin gcnt[1]++; glog.push_back(1); end
    if (done0) dcnt[0]++;
    if (done1) dcnt[1]++;
    engine_update();
    if (rand_mode) requester_update();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    r_req    = '{1'b0, 1'b0};
    granted  = '{1'b0, 1'b0};
    en_force = 1'b0;
    tick();
    rst  = 1'b0;
    gcnt = '{0, 0};
    dcnt = '{0, 0};
    glog.delete();
  endtask

  task automatic wait_done(input int p, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!((p == 1) ? done1 : done0) && n < 60);
    if (!((p == 1) ? done1 : done0)) check({tag, "_timeout"}, (p == 1) ? done1 : done0, 1);
  endtask

  task automatic settle();
    int n = 0;
    while ((m_stage != 0 || eng_complete) && n < 60) begin
      tick();
      n++;
    end
    if (m_stage != 0) check("settle_timeout", m_stage, 0);
  endtask

  int gap, dsave, n;

  initial begin
    rst = 1'b1;
    r_req = '{1'b0, 1'b0};
    r_a = '{'0, '0};
    r_b = '{'0, '0};
    eng_complete = 1'b0;
    eng_gcd = '0;
    en_pending = 1'b0; en_out = 1'b0; en_force = 1'b0;
    en_hold = 0; en_cnt = 0; dly_cfg = 0; hold_cfg = 0;
    m_stage = 0; m_last = 1; m_owner = 0;

    do_reset();
    check("rst_gcd0", gcd0, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_gnt0", gnt0, 0);

    // Single requester, (12,18)
    r_a[0] = 12; r_b[0] = 18; r_req[0] = 1'b1;
    tick();
    check("d1_gnt0", gnt0, 1);
    check("d1_begin", eng_begin, 1);
    check("d1_eng_a", eng_a, 12);
    check("d1_eng_b", eng_b, 18);
    wait_done(0, "d1_done0");
    r_req[0] = 1'b0;
    check("d1_gcd0", gcd0, 6);
    settle();

    // Simultaneous requests after reset: port 0 first
    do_reset();
    r_a[0] = 48; r_b[0] = 36; r_a[1] = 35; r_b[1] = 14;
    r_req = '{1'b1, 1'b1};
    wait_done(0, "d2_done0");
    r_req[0] = 1'b0;
    check("d2_gcd0", gcd0, 12);
    wait_done(1, "d2_done1");
    r_req[1] = 1'b0;
    check("d2_gcd1", gcd1, 7);
    check("d2_first", glog[0], 0);
    check("d2_second", glog[1], 1);
    settle();

    // Both held: alternation and one done per grant
    do_reset();
    r_a[0] = 20; r_b[0] = 30; r_a[1] = 81; r_b[1] = 27;
    r_req = '{1'b1, 1'b1};
    n = 0;
    while (dcnt[0] + dcnt[1] < 4 && n < 300) begin tick(); n++; end
    r_req = '{1'b0, 1'b0};
    settle();
    check("d3_ngrants", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) check("d3_order", glog[i], i % 2);
    check("d3_done0", dcnt[0], 2);
    check("d3_done1", dcnt[1], 2);

    // Completion held three cycles
    dly_cfg = 2; hold_cfg = 3;
    r_a[0] = 100; r_b[0] = 75; r_req[0] = 1'b1;
    wait_done(0, "d4_done0");
    dsave = dcnt[0];
    gap = cyc;
    r_req[0] = 1'b0;
    r_a[1] = 91; r_b[1] = 26; r_req[1] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!gnt1 && n < 30);
    check("d4_gnt_gap", cyc - gap, 4);
    check("d4_one_done", dcnt[0], dsave);
    wait_done(1, "d4_done1");
    r_req[1] = 1'b0;
    check("d4_gcd1", gcd1, 13);
    dly_cfg = 0; hold_cfg = 0;
    settle();

    // Zero operand on port 1
    r_a[1] = 0; r_b[1] = 9; r_req[1] = 1'b1;
    tick();
    check("d5_gnt1", gnt1, 1);
    if (BYPASS) begin
      check("d5_done1", done1, 1);
      check("d5_gcd1", gcd1, 9);
      check("d5_nobegin", eng_begin, 0);
      r_req[1] = 1'b0;
    end else begin
      check("d5_begin", eng_begin, 1);
      check("d5_eng_b", eng_b, 9);
      wait_done(1, "d5_done1");
      r_req[1] = 1'b0;
      check("d5_gcd1", gcd1, 9);
    end
    settle();

    // No grant while eng_complete is high in IDLE
    en_force = 1'b1; eng_complete = 1'b1;
    r_a[0] = 5; r_b[0] = 10; r_req[0] = 1'b1;
    repeat (3) begin
      tick();
      check("d6_no_gnt", gnt0, 0);
    end
    en_force = 1'b0; eng_complete = en_out;
    wait_done(0, "d6_done0");
    r_req[0] = 1'b0;
    check("d6_gcd0", gcd0, 5);
    settle();

    // Reset while BUSY
    dly_cfg = 4;
    r_a[0] = 30; r_b[0] = 45; r_req[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b1; r_req[0] = 1'b0;
    tick();
    rst = 1'b0;
    check("d7_gnt0", gnt0, 0);
    check("d7_gnt1", gnt1, 0);
    check("d7_done0", done0, 0);
    check("d7_done1", done1, 0);
    check("d7_begin", eng_begin, 0);
    check("d7_gcd0", gcd0, 0);
    check("d7_gcd1", gcd1, 0);
    check("d7_eng_a", eng_a, 0);
    check("d7_eng_b", eng_b, 0);
    dsave = dcnt[0];
    repeat (8) tick();
    check("d7_no_done", dcnt[0], dsave);
    dly_cfg = 0;
    r_a[0] = 7; r_b[0] = 21; r_req[0] = 1'b1;
    wait_done(0, "d7_done0");
    r_req[0] = 1'b0;
    check("d7_gcd0_new", gcd0, 7);
    settle();

    // Randomized traffic
    do_reset();
    rand_mode = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    r_req = '{1'b0, 1'b0};
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
